// File: rtl/jb_prach_fft_gain_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// jb_prach_gain_pkg
// Shared types and constants for the PRACH FFT gain controller.
//   gain_t        : {sign, scalar, fraction} gain word driven to the multiplier
//   GAIN_DEF_6DB  : default gain for 20/10 MHz carriers
//   GAIN_DEF_3DB  : default gain for the other bandwidth codes
//   state_t       : commit scheduler states
//   default_gain_for_bw() : reset gain selected from the ch_bw code; only used
//   when JB_PRACH_GAIN_BW_DEFAULT_EN is defined.
// -----------------------------------------------------------------------------
package jb_prach_gain_pkg;

    localparam int PKG_USR_ID_BW = 2;
    localparam int PKG_PRECISION = 16;
    localparam int PKG_SCALER_BW = 4;

    localparam logic [3:0] CH_BW_20MHZ = 4'b0000;
    localparam logic [3:0] CH_BW_10MHZ = 4'b0001;

    typedef struct packed {
        logic                     sign;      // 0 = shift left, 1 = shift right
        logic [PKG_SCALER_BW-1:0] scalar;
        logic [PKG_PRECISION-1:0] fraction;
    } gain_t;

    localparam gain_t GAIN_DEF_6DB = '{sign: 1'b0, scalar: PKG_SCALER_BW'(2), fraction: PKG_PRECISION'('h809C)};
    localparam gain_t GAIN_DEF_3DB = '{sign: 1'b0, scalar: PKG_SCALER_BW'(1), fraction: PKG_PRECISION'('hB573)};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        APPLY   = 2'd2
    } state_t;

    // 20 and 10 MHz carriers get the 6 dB default, everything else 3 dB.
    function automatic gain_t default_gain_for_bw(input logic [3:0] ch_bw);
        if (ch_bw == CH_BW_20MHZ || ch_bw == CH_BW_10MHZ) begin
            return GAIN_DEF_6DB;
        end
        return GAIN_DEF_3DB;
    endfunction

endpackage

// File: rtl/jb_prach_fft_gain_ctrl_if.sv
// -----------------------------------------------------------------------------
// jb_prach_fft_gain_ctrl_if
// Bundles the stream snoop, the software configuration port and the gain
// outputs of jb_prach_fft_gain_ctrl.
//   mon_*        : snoop of the AXI4-stream feeding the IQ gain multiplier
//   cfg_wr_*     : shadow table write port
//   cfg_commit   : shadow-to-active copy request; cfg_busy / cfg_done status
//   gain_*       : gain inputs of the multiplier
// Modports: master = stream/software side, slave = gain controller.
// -----------------------------------------------------------------------------
interface jb_prach_fft_gain_ctrl_if
    import jb_prach_gain_pkg::*;
#(
    parameter int USR_ID_BW      = PKG_USR_ID_BW,
    parameter int PRECISION      = PKG_PRECISION,
    parameter int GAIN_SCALER_BW = PKG_SCALER_BW
);
    logic                      mon_tvalid;
    logic                      mon_tready;
    logic                      mon_tlast;
    logic [USR_ID_BW-1:0]      mon_tuser;

    logic                      cfg_wr_en;
    logic [USR_ID_BW-1:0]      cfg_wr_addr;
    logic                      cfg_wr_sign;
    logic [GAIN_SCALER_BW-1:0] cfg_wr_scalar;
    logic [PRECISION-1:0]      cfg_wr_fraction;
    logic                      cfg_commit;
    logic                      cfg_busy;
    logic                      cfg_done;

    logic                      gain_scalar_sign;
    logic [GAIN_SCALER_BW-1:0] gain_scalar;
    logic [PRECISION-1:0]      gain_fraction;

    modport master (
        output mon_tvalid, mon_tready, mon_tlast, mon_tuser,
        output cfg_wr_en, cfg_wr_addr, cfg_wr_sign, cfg_wr_scalar, cfg_wr_fraction,
        output cfg_commit,
        input  cfg_busy, cfg_done,
        input  gain_scalar_sign, gain_scalar, gain_fraction
    );

    modport slave (
        input  mon_tvalid, mon_tready, mon_tlast, mon_tuser,
        input  cfg_wr_en, cfg_wr_addr, cfg_wr_sign, cfg_wr_scalar, cfg_wr_fraction,
        input  cfg_commit,
        output cfg_busy, cfg_done,
        output gain_scalar_sign, gain_scalar, gain_fraction
    );

endinterface

// File: rtl/jb_prach_fft_gain_ctrl_table.sv
// -----------------------------------------------------------------------------
// jb_prach_gain_table
// Dual-bank (shadow / active) gain register file, one word per carrier.
//   clk, reset              : clock, synchronous active-high reset
//   def_*                   : value loaded into every entry of both banks on reset
//   wr_en/wr_addr/wr_*      : shadow write port
//   copy                    : bulk copy of the whole shadow bank into active
//   rd_addr / rd_*          : active word as it will stand after this edge
//                             (shadow content when copy is high), so a register
//                             sampling it tracks the active bank with no lag
// A write and a copy in the same cycle copy the pre-write shadow content.
// -----------------------------------------------------------------------------
module jb_prach_gain_table
    import jb_prach_gain_pkg::*;
#(
    parameter int ID_BW     = PKG_USR_ID_BW,
    parameter int FRAC_BW   = PKG_PRECISION,
    parameter int SCALER_BW = PKG_SCALER_BW
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 def_sign,
    input  logic [SCALER_BW-1:0] def_scalar,
    input  logic [FRAC_BW-1:0]   def_fraction,
    input  logic                 wr_en,
    input  logic [ID_BW-1:0]     wr_addr,
    input  logic                 wr_sign,
    input  logic [SCALER_BW-1:0] wr_scalar,
    input  logic [FRAC_BW-1:0]   wr_fraction,
    input  logic                 copy,
    input  logic [ID_BW-1:0]     rd_addr,
    output logic                 rd_sign,
    output logic [SCALER_BW-1:0] rd_scalar,
    output logic [FRAC_BW-1:0]   rd_fraction
);
    localparam int DEPTH   = 2 ** ID_BW;
    localparam int WORD_BW = 1 + SCALER_BW + FRAC_BW;

    logic [DEPTH-1:0][WORD_BW-1:0] shadow;
    logic [DEPTH-1:0][WORD_BW-1:0] active;
    logic [WORD_BW-1:0]            def_word;
    logic [WORD_BW-1:0]            wr_word;
    logic [WORD_BW-1:0]            rd_word;

    assign def_word = {def_sign, def_scalar, def_fraction};
    assign wr_word  = {wr_sign, wr_scalar, wr_fraction};

    // NOTE: this table is tiny and its reset content is functional (the
    // multiplier must see a valid gain right after reset), so both banks are
    // reset as flops; a large RAM would not be reset this way.
    // NOTE: sequential state uses non-blocking assignments so the copy reads
    // the shadow value from before this edge's write, independent of order.
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow <= {DEPTH{def_word}};
            active <= {DEPTH{def_word}};
        end else begin
            if (wr_en) begin
                shadow[wr_addr] <= wr_word;
            end
            if (copy) begin
                active <= shadow;
            end
        end
    end

    assign rd_word = copy ? shadow[rd_addr] : active[rd_addr];
    assign {rd_sign, rd_scalar, rd_fraction} = rd_word;

endmodule

// File: rtl/jb_prach_fft_gain_ctrl.sv
// -----------------------------------------------------------------------------
// jb_prach_fft_gain_ctrl
// Per-carrier gain scheduler for the PRACH FFT gain stage. Tracks packets on
// the snooped multiplier input stream, drives the multiplier gain with the
// active entry of the in-flight carrier, and commits software shadow writes
// to the active bank only between packets.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   clk_en     : global enable, all state holds while low
//   ch_bw      : bandwidth code, selects reset defaults (sampled during reset)
//   bus        : jb_prach_fft_gain_ctrl_if.slave (snoop, config, gain outputs)
// Build option: JB_PRACH_GAIN_BW_DEFAULT_EN selects reset defaults from ch_bw;
// without it every entry resets to the 6 dB gain and ch_bw is unused.
// -----------------------------------------------------------------------------
module jb_prach_fft_gain_ctrl
    import jb_prach_gain_pkg::*;
#(
    parameter int USR_ID_BW      = PKG_USR_ID_BW,
    parameter int PRECISION      = PKG_PRECISION,
    parameter int GAIN_SCALER_BW = PKG_SCALER_BW
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clk_en,
    input  logic [3:0] ch_bw,
    jb_prach_fft_gain_ctrl_if.slave bus
);
    state_t                    state;
    logic                      in_pkt;
    logic [USR_ID_BW-1:0]      cur_id;
    logic                      beat_acc;
    logic                      sop;
    logic [USR_ID_BW-1:0]      next_id;
    logic                      tbl_wr_en;
    logic                      tbl_copy;
    gain_t                     reset_gain;
    logic                      rd_sign;
    logic [GAIN_SCALER_BW-1:0] rd_scalar;
    logic [PRECISION-1:0]      rd_fraction;

`ifdef JB_PRACH_GAIN_BW_DEFAULT_EN
    assign reset_gain = default_gain_for_bw(ch_bw);
`else
    logic unused_ch_bw;
    assign reset_gain   = GAIN_DEF_6DB;
    assign unused_ch_bw = ^ch_bw;
`endif

    assign beat_acc  = clk_en & bus.mon_tvalid & bus.mon_tready;
    assign sop       = beat_acc & ~in_pkt;
    // Carrier the outputs must show after this edge: a new packet's ID takes
    // effect right away so the gain lands one cycle after the SOP beat.
    assign next_id   = sop ? bus.mon_tuser : cur_id;
    assign tbl_wr_en = clk_en & bus.cfg_wr_en;
    assign tbl_copy  = clk_en & (state == APPLY);

    jb_prach_gain_table #(
        .ID_BW     (USR_ID_BW),
        .FRAC_BW   (PRECISION),
        .SCALER_BW (GAIN_SCALER_BW)
    ) u_table (
        .clk          (clk),
        .reset        (reset),
        .def_sign     (reset_gain.sign),
        .def_scalar   (GAIN_SCALER_BW'(reset_gain.scalar)),
        .def_fraction (PRECISION'(reset_gain.fraction)),
        .wr_en        (tbl_wr_en),
        .wr_addr      (bus.cfg_wr_addr),
        .wr_sign      (bus.cfg_wr_sign),
        .wr_scalar    (bus.cfg_wr_scalar),
        .wr_fraction  (bus.cfg_wr_fraction),
        .copy         (tbl_copy),
        .rd_addr      (next_id),
        .rd_sign      (rd_sign),
        .rd_scalar    (rd_scalar),
        .rd_fraction  (rd_fraction)
    );

    // Packet tracker: a tlast beat always closes the packet, so a single-beat
    // packet never leaves in_pkt set.
    always_ff @(posedge clk) begin
        if (reset) begin
            in_pkt <= 1'b0;
            cur_id <= '0;
        end else if (beat_acc) begin
            in_pkt <= ~bus.mon_tlast;
            if (sop) begin
                cur_id <= bus.mon_tuser;
            end
        end
    end

    // Commit scheduler. cfg_commit is only looked at in IDLE, which absorbs
    // repeated requests while one is pending or being applied.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            bus.cfg_busy <= 1'b0;
            bus.cfg_done <= 1'b0;
        end else if (clk_en) begin
            bus.cfg_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.cfg_commit) begin
                        state        <= PENDING;
                        bus.cfg_busy <= 1'b1;
                    end
                end
                PENDING: begin
                    // A SOP this cycle means a packet is starting: keep waiting.
                    if (!in_pkt && !sop) begin
                        state        <= APPLY;
                        bus.cfg_done <= 1'b1;
                    end
                end
                APPLY: begin
                    state        <= IDLE;
                    bus.cfg_busy <= 1'b0;
                end
                default: begin
                    state        <= IDLE;
                    bus.cfg_busy <= 1'b0;
                end
            endcase
        end
    end

    // Gain output registers follow active[cur_id].
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.gain_scalar_sign <= reset_gain.sign;
            bus.gain_scalar      <= GAIN_SCALER_BW'(reset_gain.scalar);
            bus.gain_fraction    <= PRECISION'(reset_gain.fraction);
        end else if (clk_en) begin
            bus.gain_scalar_sign <= rd_sign;
            bus.gain_scalar      <= rd_scalar;
            bus.gain_fraction    <= rd_fraction;
        end
    end

endmodule

// File: tb/tb_jb_prach_fft_gain_ctrl.sv
// -----------------------------------------------------------------------------
// tb_jb_prach_fft_gain_ctrl
// Self-checking bench for jb_prach_fft_gain_ctrl: a directed vector table,
// hand-written commit corner-case sequences, and randomized traffic checked
// against a cycle-level behavioural model of the gain tables and commit rules.
// -----------------------------------------------------------------------------
module tb_jb_prach_fft_gain_ctrl;

    localparam int ID_BW = 2;
    localparam int PREC  = 16;
    localparam int SC_BW = 4;
    localparam int NID   = 4;

    typedef struct packed {
        logic       sign;
        logic [3:0] scalar;
        logic [15:0] fraction;
    } g_t;

    localparam g_t G6 = '{1'b0, 4'd2, 16'h809C};
    localparam g_t G3 = '{1'b0, 4'd1, 16'hB573};
    localparam g_t GA = '{1'b1, 4'd3, 16'h4000};
    localparam g_t GB = '{1'b1, 4'd0, 16'h1234};
    localparam g_t GC = '{1'b0, 4'd5, 16'h1111};
    localparam g_t GD = '{1'b1, 4'd2, 16'h2222};
`ifdef JB_PRACH_GAIN_BW_DEFAULT_EN
    localparam g_t EXP_DEF_0010 = G3;
`else
    localparam g_t EXP_DEF_0010 = G6;
`endif

    typedef struct {
        logic       wr_en;
        logic [1:0] wr_addr;
        g_t         wr_val;
        logic       commit;
        logic       tvalid;
        logic       tlast;
        logic [1:0] tuser;
        g_t         exp_gain;
        logic       exp_busy;
        logic       exp_done;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       clk_en;
    logic [3:0] ch_bw;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model state.
    g_t   sh_m [NID];
    g_t   ac_m [NID];
    int   cur_m;
    bit   inpkt_m;
    int   phase_m;   // 0 no commit, 1 waiting for a packet gap, 2 copying
    bit   done_m;

    jb_prach_fft_gain_ctrl_if #(
        .USR_ID_BW      (ID_BW),
        .PRECISION      (PREC),
        .GAIN_SCALER_BW (SC_BW)
    ) bus ();

    jb_prach_fft_gain_ctrl #(
        .USR_ID_BW      (ID_BW),
        .PRECISION      (PREC),
        .GAIN_SCALER_BW (SC_BW)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .clk_en (clk_en),
        .ch_bw  (ch_bw),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    function automatic g_t def_for(input logic [3:0] bw);
`ifdef JB_PRACH_GAIN_BW_DEFAULT_EN
        return (bw == 4'd0 || bw == 4'd1) ? G6 : G3;
`else
        return G6;
`endif
    endfunction

    function automatic g_t dut_gain();
        return {bus.gain_scalar_sign, bus.gain_scalar, bus.gain_fraction};
    endfunction

    function automatic vec_t mk(input logic we, input logic [1:0] wa, input g_t wv,
                                input logic cm, input logic tv, input logic tl,
                                input logic [1:0] tu, input g_t eg,
                                input logic eb, input logic ed);
        vec_t v;
        v.wr_en = we; v.wr_addr = wa; v.wr_val = wv; v.commit = cm;
        v.tvalid = tv; v.tlast = tl; v.tuser = tu;
        v.exp_gain = eg; v.exp_busy = eb; v.exp_done = ed;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic we, input logic [1:0] wa, input g_t wv,
                         input logic cm, input logic tv, input logic tl,
                         input logic [1:0] tu);
        bus.cfg_wr_en       = we;
        bus.cfg_wr_addr     = wa;
        bus.cfg_wr_sign     = wv.sign;
        bus.cfg_wr_scalar   = wv.scalar;
        bus.cfg_wr_fraction = wv.fraction;
        bus.cfg_commit      = cm;
        bus.mon_tvalid      = tv;
        bus.mon_tready      = 1'b1;
        bus.mon_tlast       = tl;
        bus.mon_tuser       = tu;
    endtask

    task automatic drive_idle();
        drive(1'b0, 2'd0, G6, 1'b0, 1'b0, 1'b0, 2'd0);
    endtask

    // Advance the model by one clock using the inputs presented this cycle.
    task automatic model_step();
        bit acc, sop, nd;
        if (reset) begin
            for (int i = 0; i < NID; i++) begin
                sh_m[i] = def_for(ch_bw);
                ac_m[i] = def_for(ch_bw);
            end
            cur_m = 0; inpkt_m = 0; phase_m = 0; done_m = 0;
        end else if (clk_en) begin
            acc = bus.mon_tvalid && bus.mon_tready;
            sop = acc && !inpkt_m;
            nd  = 0;
            if (phase_m == 2) begin
                for (int i = 0; i < NID; i++) ac_m[i] = sh_m[i];
                phase_m = 0;
            end else if (phase_m == 1) begin
                if (!inpkt_m && !sop) begin
                    phase_m = 2;
                    nd = 1;
                end
            end else if (bus.cfg_commit) begin
                phase_m = 1;
            end
            if (bus.cfg_wr_en)
                sh_m[bus.cfg_wr_addr] = {bus.cfg_wr_sign, bus.cfg_wr_scalar, bus.cfg_wr_fraction};
            if (sop) cur_m = int'(bus.mon_tuser);
            if (acc) inpkt_m = !bus.mon_tlast;
            done_m = nd;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, "_gain"}, 32'(dut_gain()), 32'(ac_m[cur_m]));
        check({tag, "_busy"}, 32'(bus.cfg_busy), 32'(phase_m != 0));
        check({tag, "_done"}, 32'(bus.cfg_done), 32'(done_m));
    endtask

    initial begin
        vec_t tbl [15];
        g_t   pre;
        int   dones;

        // ---- reset defaults with ch_bw = 0010 ----
        reset = 1'b1; clk_en = 1'b1; ch_bw = 4'b0010;
        drive_idle();
        tick(); tick();
        check("rst_gain_0010", 32'(dut_gain()), 32'(EXP_DEF_0010));
        check("rst_busy", 32'(bus.cfg_busy), 32'd0);
        check("rst_done", 32'(bus.cfg_done), 32'd0);

        // ---- directed vector table, from a reset with ch_bw = 0000 ----
        ch_bw = 4'b0000;
        tick();
        reset = 1'b0;
        check("rst_gain_0000", 32'(dut_gain()), 32'(G6));

        tbl[0]  = mk(1, 2'd1, GA, 0, 0, 0, 2'd0, G6, 0, 0);
        tbl[1]  = mk(0, 2'd0, G6, 1, 0, 0, 2'd0, G6, 1, 0);
        tbl[2]  = mk(0, 2'd0, G6, 0, 0, 0, 2'd0, G6, 1, 1);
        tbl[3]  = mk(0, 2'd0, G6, 0, 0, 0, 2'd0, G6, 0, 0);
        tbl[4]  = mk(0, 2'd0, G6, 0, 1, 0, 2'd1, GA, 0, 0);
        tbl[5]  = mk(0, 2'd0, G6, 0, 1, 1, 2'd1, GA, 0, 0);
        tbl[6]  = mk(0, 2'd0, G6, 0, 0, 0, 2'd0, GA, 0, 0);
        tbl[7]  = mk(0, 2'd0, G6, 0, 1, 1, 2'd0, G6, 0, 0);
        tbl[8]  = mk(1, 2'd0, GB, 0, 0, 0, 2'd0, G6, 0, 0);
        tbl[9]  = mk(0, 2'd0, G6, 1, 0, 0, 2'd0, G6, 1, 0);
        tbl[10] = mk(0, 2'd0, G6, 0, 1, 0, 2'd2, G6, 1, 0);
        tbl[11] = mk(0, 2'd0, G6, 0, 1, 1, 2'd2, G6, 1, 0);
        tbl[12] = mk(0, 2'd0, G6, 0, 0, 0, 2'd0, G6, 1, 1);
        tbl[13] = mk(0, 2'd0, G6, 0, 0, 0, 2'd0, G6, 0, 0);
        tbl[14] = mk(0, 2'd0, G6, 0, 1, 1, 2'd0, GB, 0, 0);

        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].wr_en, tbl[i].wr_addr, tbl[i].wr_val, tbl[i].commit,
                  tbl[i].tvalid, tbl[i].tlast, tbl[i].tuser);
            tick();
            check($sformatf("vec%0d_gain", i), 32'(dut_gain()), 32'(tbl[i].exp_gain));
            check($sformatf("vec%0d_busy", i), 32'(bus.cfg_busy), 32'(tbl[i].exp_busy));
            check($sformatf("vec%0d_done", i), 32'(bus.cfg_done), 32'(tbl[i].exp_done));
        end
        drive_idle();
        tick();
        check_model("post_table");

        // ---- commit in the middle of an 8-beat carrier-0 packet ----
        drive(1, 2'd0, GC, 0, 0, 0, 2'd0);
        tick();
        pre = ac_m[0];
        for (int b = 0; b < 8; b++) begin
            drive(0, 2'd0, G6, b == 2, 1, b == 7, 2'd0);
            tick();
            check_model("midpkt");
            check("midpkt_gain_hold", 32'(dut_gain()), 32'(pre));
            if (b >= 2) check("midpkt_busy", 32'(bus.cfg_busy), 32'd1);
        end
        drive_idle();
        tick();
        check("midpkt_done_gap", 32'(bus.cfg_done), 32'd1);
        tick();
        check("midpkt_new_gain", 32'(dut_gain()), 32'(GC));
        check_model("midpkt_end");

        // ---- back-to-back packets, commit during the first ----
        drive(1, 2'd0, GD, 0, 0, 0, 2'd0);
        tick();
        pre = ac_m[0];
        dones = 0;
        for (int b = 0; b < 8; b++) begin
            drive(0, 2'd0, G6, b == 1, 1, (b == 3) || (b == 7), 2'd0);
            tick();
            check_model("b2b");
            check("b2b_gain_hold", 32'(dut_gain()), 32'(pre));
            if (bus.cfg_done) dones++;
        end
        check("b2b_no_done_in_pkts", 32'(dones), 32'd0);
        drive_idle();
        tick();
        check("b2b_done_gap", 32'(bus.cfg_done), 32'd1);
        tick();
        check("b2b_new_gain", 32'(dut_gain()), 32'(GD));

        // ---- two commit pulses one cycle apart ----
        dones = 0;
        for (int c = 0; c < 8; c++) begin
            drive(0, 2'd0, G6, (c == 0) || (c == 2), 0, 0, 2'd0);
            tick();
            check_model("dbl");
            if (bus.cfg_done) dones++;
        end
        check("dbl_single_done", 32'(dones), 32'd1);

        // ---- clk_en low during PENDING, then reset mid-packet ----
        drive(0, 2'd0, G6, 0, 1, 0, 2'd1);
        tick();
        check_model("frz_sop");
        drive(0, 2'd0, G6, 1, 0, 0, 2'd1);
        tick();
        check("frz_pending", 32'(bus.cfg_busy), 32'd1);
        pre = ac_m[1];
        clk_en = 1'b0;
        for (int c = 0; c < 5; c++) begin
            drive(1, 2'd1, GB, 1, 1, 1, 2'd3);
            tick();
            check_model("frz");
            check("frz_busy", 32'(bus.cfg_busy), 32'd1);
            check("frz_gain", 32'(dut_gain()), 32'(pre));
        end
        clk_en = 1'b1;
        ch_bw = 4'b0010;
        reset = 1'b1;
        drive(0, 2'd0, G6, 0, 1, 0, 2'd1);
        tick();
        reset = 1'b0;
        drive_idle();
        dones = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            check_model("rstmid");
            check("rstmid_gain", 32'(dut_gain()), 32'(EXP_DEF_0010));
            check("rstmid_busy", 32'(bus.cfg_busy), 32'd0);
            if (bus.cfg_done) dones++;
        end
        check("rstmid_no_done", 32'(dones), 32'd0);

        // ---- randomized traffic against the model ----
        for (int c = 0; c < 3000; c++) begin
            g_t rv;
            rv = g_t'($urandom);
            reset  = ($urandom_range(0, 499) == 0);
            ch_bw  = 4'($urandom_range(0, 4));
            clk_en = ($urandom_range(0, 9) != 0);
            drive($urandom_range(0, 5) == 0, 2'($urandom), rv,
                  $urandom_range(0, 19) == 0,
                  $urandom_range(0, 9) < 6, $urandom_range(0, 3) == 0, 2'($urandom));
            bus.mon_tready = ($urandom_range(0, 4) != 0);
            tick();
            check_model("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/jb_prach_fft_gain_ctrl.md
# jb_prach_fft_gain_ctrl

Per-carrier gain scheduler for the PRACH FFT gain stage. It holds an active and a shadow table of {sign, scaler, fraction} gain words, one per carrier (user ID). It snoops the AXI4-stream feeding the IQ gain multiplier and drives that multiplier's gain inputs with the active entry of the carrier whose packet is in flight. Software-written shadow values are committed atomically, only at a packet boundary, so gain never changes mid-symbol.

## Interface
- USR_ID_BW, 2: carrier/user ID width; table depth = 2**USR_ID_BW
- PRECISION, 16: fraction gain width
- GAIN_SCALER_BW, 4: integer scaler width
- clk, in, 1: single clock
- reset, in, 1: synchronous, active-high
- clk_en, in, 1: global enable; when low, all state holds and stream beats are ignored
- ch_bw, in, 4: channel bandwidth code (0000 20 MHz, 0001 10 MHz, 0010 5 MHz, 0011 15 MHz)
- mon_tvalid / mon_tready / mon_tlast, in, 1 each: snoop of the multiplier input stream
- mon_tuser, in, USR_ID_BW: carrier ID of the current beat
- cfg_wr_en, in, 1: shadow write strobe
- cfg_wr_addr, in, USR_ID_BW: shadow entry index
- cfg_wr_sign, in, 1: 0 = shift left, 1 = shift right
- cfg_wr_scalar, in, GAIN_SCALER_BW: scaler value
- cfg_wr_fraction, in, PRECISION: fraction value
- cfg_commit, in, 1: request shadow-to-active copy
- cfg_busy, out, 1: commit pending
- cfg_done, out, 1: one-cycle pulse when the copy is performed
- gain_scalar_sign, out, 1: multiplier shift direction
- gain_scalar, out, GAIN_SCALER_BW: multiplier scaler
- gain_fraction, out, PRECISION: multiplier fraction

## Operation
- Beat accepted = clk_en & mon_tvalid & mon_tready. SOP = accepted beat while in_pkt = 0.
- in_pkt is set on SOP and cleared on an accepted beat with mon_tlast. A single-beat packet (SOP with tlast) leaves in_pkt at 0.
- On SOP, cur_id <= mon_tuser. The gain outputs are registered and always reflect active[cur_id].
- Shadow writes apply whenever cfg_wr_en & clk_en, in any state.
- FSM states:
  - IDLE: on cfg_commit -> PENDING.
  - PENDING: if in_pkt = 0 and no SOP this cycle -> APPLY; otherwise stay.
  - APPLY: copy all shadow entries to active, pulse cfg_done, then -> IDLE.
- cfg_commit asserted in PENDING or APPLY is absorbed, and only one cfg_done is issued. A commit in APPLY is not re-queued.
- Shadow writes made in PENDING are included in the copy.
- If APPLY changes active[cur_id], the outputs update the cycle after APPLY. This is legal because the stream is between packets.
- cfg_busy = (state != IDLE).
- Reset loads both tables with the defaults described under Configuration. It also sets cur_id = 0, in_pkt = 0, state = IDLE and cfg_done = 0. Outputs then equal the entry 0 defaults. Reset mid-packet or mid-commit discards the pending commit.

## Timing
- Gain output latency: 1 cycle after the SOP beat, matching the multiplier's stage-1 sampling of gain.
- Commit latency with the stream idle: cfg_commit at cycle N -> PENDING at N+1 -> APPLY at N+2 -> cfg_done high during N+2 -> new gain on outputs at N+3.
- If tlast is accepted in the same cycle as cfg_commit, the boundary is seen in PENDING on the next cycle.
- If SOP and tlast for the next packet occur back-to-back with no idle cycle, PENDING waits for the first cycle with in_pkt = 0 and no SOP.
- While clk_en is low, the FSM, counters and outputs freeze, and a held cfg_done is not re-pulsed.

## Configuration
- JB_PRACH_GAIN_BW_DEFAULT_EN defined: reset defaults are selected from ch_bw, identically for all entries.
  - 0000 or 0001: sign 0, scalar 2, fraction 'h809C.
  - Any other code: sign 0, scalar 1, fraction 'hB573.
  - ch_bw is sampled only during reset.
- Not defined: all entries reset to sign 0, scalar 2, fraction 'h809C, and ch_bw is unused.

## Structure
- Package jb_prach_gain_pkg holds:
  - gain_t struct {sign, scalar, fraction}, parameterised through package localparams.
  - GAIN_DEF_6DB = {0, 2, 'h809C} and GAIN_DEF_3DB = {0, 1, 'hB573}.
  - A state enum {IDLE, PENDING, APPLY}.
- Sub-module jb_prach_gain_table: the dual-bank shadow/active register file with a write port, a bulk-copy strobe and a read port indexed by cur_id.
- The top level holds the FSM, the packet tracker and the output registers.

## Test plan
- Reset with the macro defined and ch_bw = 0010 -> outputs 0/1/'hB573. Undefined -> 0/2/'h809C.
- Write entry 1 = {1, 3, 'h4000}, then commit with the stream idle -> cfg_done at N+2. A packet with tuser = 1 then drives outputs 1/3/'h4000 one cycle after its SOP.
- Commit mid-packet (8 beats, carrier 0) -> cfg_busy stays high until after tlast and the active table is unchanged during the packet. cfg_done is asserted in the first idle cycle after tlast.
- Back-to-back packets with no gap, commit during the first -> APPLY is deferred to the first gap, and no gain change occurs mid-packet.
- Two cfg_commit pulses 1 cycle apart -> a single cfg_done.
- clk_en low for 5 cycles during PENDING, then reset asserted mid-packet -> state frozen while clk_en is low, then defaults restored and no cfg_done.
